bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 97 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter; `define LEADING_ZERO_BLANK_EN blanks leading zeros with 4'hF
module bin_to_bcd_seq #(
  parameter int BIN_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [BIN_W-1:0] Bin_in,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Digit3,
  output logic [3:0]       Digit2,
  output logic [3:0]       Digit1,
  output logic [3:0]       Digit0,
  output logic             Overflow
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [19:0]      bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      dig_q, dig_d;
  logic             ovf_q, ovf_d;

  function automatic logic [15:0] fmt(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    logic b3, b2, b1;
    b3 = d[15:12] == 4'd0;
    b2 = b3 && d[11:8] == 4'd0;
    b1 = b2 && d[7:4] == 4'd0;
    return {b3 ? 4'hF : d[15:12], b2 ? 4'hF : d[11:8], b1 ? 4'hF : d[7:4], d[3:0]};
`else
    return d;
`endif
  endfunction

  // add-3 correction on every scratch nibble that would overflow a decimal digit when doubled
  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end

  // next state: capture on Start, shift BIN_W times, publish result on the way into DONE
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (Start) begin
        bin_d   = Bin_in;
        bcd_d   = '0;
        cnt_d   = CW'(BIN_W);
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[18:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          ovf_d   = |bcd_d[19:16] | adj[19];
          dig_d   = ovf_d ? 16'hFFFF : fmt(bcd_d[15:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy     = state_q != IDLE;
  assign Done     = state_q == DONE;
  assign Overflow = ovf_q;
  assign {Digit3, Digit2, Digit1, Digit0} = dig_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench against an arithmetic decimal model
module tb_bin_to_bcd_seq;
  logic        Clk, Rst_n, Start, Busy, Done, Overflow;
  logic [15:0] Bin_in;
  logic [3:0]  Digit3, Digit2, Digit1, Digit0;
  logic [15:0] digs;
  int          total, bad;

  bin_to_bcd_seq #(.BIN_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Bin_in(Bin_in), .Start(Start), .Busy(Busy), .Done(Done),
    .Digit3(Digit3), .Digit2(Digit2), .Digit1(Digit1), .Digit0(Digit0), .Overflow(Overflow)
  );

  assign digs = {Digit3, Digit2, Digit1, Digit0};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // decimal reference: {overflow, d3, d2, d1, d0}
  function automatic logic [16:0] ref_conv(input int v);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return {1'b1, 16'hFFFF};
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (d3 == 4'd0) begin
      d3 = 4'hF;
      if (d2 == 4'd0) begin
        d2 = 4'hF;
        if (d1 == 4'd0) d1 = 4'hF;
      end
    end
`endif
    return {1'b0, d3, d2, d1, d0};
  endfunction

  // drive one request and watch it; starts and ends at 1ns after a rising edge
  task automatic run_conv(input int v, input int inj, input int rst_at,
                          output logic [16:0] res, output int done_at, output int busy_n,
                          output int dn, output logic [17:0] snap);
    res = '0; done_at = 0; busy_n = 0; dn = 0; snap = '1;
    Bin_in = 16'(v);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Bin_in = 16'($urandom_range(0, 65535));
    for (int k = 1; k <= 40; k++) begin
      if (rst_at == k) begin
        Rst_n = 1'b0;
        #1;
        snap = {Busy, Done, Overflow, digs[14:0]} | {15'd0, 3'd0} | (digs[15] ? 18'h3FFFF : 18'h0);
        #2;
        Rst_n = 1'b1;
      end
      if (Busy) busy_n++;
      if (Done) begin
        dn++;
        if (done_at == 0) begin
          done_at = k;
          res = {Overflow, digs};
        end
        Start = 1'b0;
      end
      if (inj == k) begin
        Start = 1'b1;
        Bin_in = 16'd42;
      end
      if (!Busy) break;
      @(posedge Clk); #1;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b1; Bin_in = 16'd1234;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if ({Busy, Done, Overflow} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got busy/done/ovf=%b expected 000", {Busy, Done, Overflow});
    end
    total++;
    if (digs !== 16'h0000) begin
      bad++; $display("FAIL reset_digits: got %h expected 0000", digs);
    end
    Start = 1'b0;
    Rst_n = 1'b1;
  endtask

  task automatic test_4092();
    logic [16:0] res; logic [17:0] snap; int da, bn, dn;
    run_conv(4092, 0, 0, res, da, bn, dn, snap);
    total++;
    if (res !== {1'b0, 16'h4092}) begin
      bad++; $display("FAIL conv_4092: got %h expected %h", res, {1'b0, ref_conv(4092) == {1'b0, 16'h0092} ? 16'h0092 : 16'h4092});
    end
    total++;
    if (da !== 17) begin
      bad++; $display("FAIL latency_4092: got %0d expected 17", da);
    end
    total++;
    if (bn !== 17) begin
      bad++; $display("FAIL busy_len_4092: got %0d expected 17", bn);
    end
    total++;
    if (dn !== 1) begin
      bad++; $display("FAIL done_pulses_4092: got %0d expected 1", dn);
    end
    Bin_in = 16'd7777;
    repeat (5) @(posedge Clk);
    #1;
    total++;
    if ({Overflow, digs, Done} !== {1'b0, 16'h4092, 1'b0}) begin
      bad++; $display("FAIL hold_4092: got %h expected %h", {Overflow, digs, Done}, {1'b0, 16'h4092, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int vals [4] = '{0, 9999, 10000, 65535};
    logic [16:0] exp_r [4] = '{{1'b0, 16'h0000}, {1'b0, 16'h9999}, {1'b1, 16'hFFFF}, {1'b1, 16'hFFFF}};
    logic [16:0] res; logic [17:0] snap; int da, bn, dn;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], 0, 0, res, da, bn, dn, snap);
`ifdef LEADING_ZERO_BLANK_EN
      exp_r[i] = ref_conv(vals[i]);
`endif
      total++;
      if (res !== exp_r[i] || da !== 17) begin
        bad++; $display("FAIL b2b_%0d: got %h at cycle %0d expected %h at cycle 17", vals[i], res, da, exp_r[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [16:0] res; logic [17:0] snap; int da, bn, dn, extra;
    run_conv(1234, 5, 0, res, da, bn, dn, snap);
    total++;
    if (res !== {1'b0, 16'h1234} || dn !== 1) begin
      bad++; $display("FAIL ignore_busy: got %h pulses=%0d expected 01234 pulses=1", res, dn);
    end
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge Clk); #1;
      if (Done || Busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL ignore_no_queue: got %0d busy cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] res; logic [17:0] snap; int da, bn, dn, extra;
    run_conv(5678, 0, 8, res, da, bn, dn, snap);
    total++;
    if (snap !== 18'd0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h expected 00000", snap);
    end
    total++;
    if (dn !== 0) begin
      bad++; $display("FAIL reset_mid_done: got %0d pulses expected 0", dn);
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (Done || Busy || Overflow || digs !== 16'h0) extra++;
      @(posedge Clk); #1;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", extra);
    end
    run_conv(5678, 0, 0, res, da, bn, dn, snap);
    total++;
    if (res !== {1'b0, 16'h5678} || da !== 17) begin
      bad++; $display("FAIL reset_mid_rerun: got %h at %0d expected 05678 at 17", res, da);
    end
  endtask

  task automatic test_blanking();
    logic [16:0] res; logic [17:0] snap; int da, bn, dn;
    int vals [3] = '{42, 0, 1005};
`ifdef LEADING_ZERO_BLANK_EN
    logic [16:0] exp_r [3] = '{{1'b0, 16'hFF42}, {1'b0, 16'hFFF0}, {1'b0, 16'h1005}};
`else
    logic [16:0] exp_r [3] = '{{1'b0, 16'h0042}, {1'b0, 16'h0000}, {1'b0, 16'h1005}};
`endif
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], 0, 0, res, da, bn, dn, snap);
      total++;
      if (res !== exp_r[i]) begin
        bad++; $display("FAIL blank_%0d: got %h expected %h", vals[i], res, exp_r[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] res, exp_v; logic [17:0] snap; int da, bn, dn, v;
    for (int i = 0; i < 30; i++) begin
      v = ($urandom % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      exp_v = ref_conv(v);
      run_conv(v, 0, 0, res, da, bn, dn, snap);
      total++;
      if (res !== exp_v || da !== 17 || bn !== 17 || dn !== 1) begin
        bad++; $display("FAIL random_%0d: got %h lat=%0d busy=%0d pulses=%0d expected %h lat=17 busy=17 pulses=1", v, res, da, bn, dn, exp_v);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    Start = 1'b0; Bin_in = '0; Rst_n = 1'b0;
    test_reset();
    test_4092();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_blanking();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
